// File: rtl/joy_scan_ctrl_pkg.sv
// Shared definitions for the serial joystick scanner: pad bit positions and
// the scan sequencer state encoding.
package joy_pkg;

  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int JOY_FIRE3 = 6;
  localparam int JOY_START = 7;

  localparam int FRAME_BITS = 16;

  typedef enum logic [2:0] {
    LOAD,
    SHIFT_HI,
    SHIFT_LO,
    COMMIT,
    IDLE
  } scan_state_t;

  // Active-low pad byte to an active-high "pressed" mask in the same layout.
  function automatic logic [7:0] pressed_mask(input logic [7:0] pad);
    return ~{pad[JOY_START], pad[JOY_FIRE3], pad[JOY_FIRE2], pad[JOY_FIRE1],
             pad[JOY_RIGHT], pad[JOY_LEFT], pad[JOY_DOWN], pad[JOY_UP]};
  endfunction

endpackage

// File: rtl/joy_scan_ctrl_if.sv
// Board-side pins of the 74x165-style joystick shifter chain.
interface joy_scan_ctrl_if;
  logic joy_load;
  logic joy_clk;
  logic joy_data;

  modport master (output joy_load, output joy_clk, input joy_data);
  modport slave  (input joy_load, input joy_clk, output joy_data);
endinterface

// File: rtl/joy_scan_ctrl_debounce.sv
// Frame debouncer: publishes a 16-bit scan word only after DEBOUNCE identical
// consecutive frames, updating both player bytes on the same edge.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  commit,
  input  logic [FRAME_BITS-1:0] word,
  output logic [7:0]            joystick1,
  output logic [7:0]            joystick2
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [FRAME_BITS-1:0] prev_word;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      next_cnt;

  always_comb begin
    next_cnt = '0;
    if (word == prev_word) begin
      next_cnt = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    end
  end

  // The comparison uses the word from the previous frame, so the output load
  // below sees exactly the word that has just been confirmed.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_word <= '1;
      cnt       <= '0;
      joystick1 <= 8'hFF;
      joystick2 <= 8'hFF;
    end else if (commit) begin
      prev_word <= word;
      cnt       <= next_cnt;
      if (next_cnt == CNT_MAX) begin
        joystick1 <= word[15:8];
        joystick2 <= word[7:0];
      end
    end
  end

endmodule

// File: rtl/joy_scan_ctrl.sv
// Scan sequencer for the shared joystick shift register: generates load/shift
// strobes, shifts in 16 bits per frame and hands each frame to the debouncer.
module joy_scan_ctrl
  import joy_pkg::*;
#(
  parameter int CLK_DIV  = 7,
  parameter int DEBOUNCE = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   enable,
  joy_scan_ctrl_if.master        pins,
  output logic [7:0]             joystick1,
  output logic [7:0]             joystick2,
  output logic                   frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  scan_state_t           state;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic                  load_second;
  logic [3:0]            bit_cnt;
  logic [1:0]            sync;
  logic                  data_s;
  logic [FRAME_BITS-1:0] shift_reg;

  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign data_s = sync[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (state == IDLE || state == COMMIT || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pins.joy_data};
    end
  end

  // Pin registers follow the current state one cycle late, and joy_clk rises
  // one further cycle into SHIFT_HI, so joy_load and joy_clk never toggle on
  // the same edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= LOAD;
      load_second   <= 1'b0;
      bit_cnt       <= '0;
      shift_reg     <= '1;
      pins.joy_load <= 1'b1;
      pins.joy_clk  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done    <= (state == COMMIT);
      pins.joy_load <= (state != LOAD);
      pins.joy_clk  <= (state == SHIFT_HI) && (div_cnt != '0);
      case (state)
        LOAD: begin
          if (tick) begin
            if (load_second) begin
              shift_reg   <= {shift_reg[FRAME_BITS-2:0], data_s};
              load_second <= 1'b0;
              state       <= SHIFT_HI;
            end else begin
              load_second <= 1'b1;
            end
          end
        end
        SHIFT_HI: begin
          if (tick) state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (tick) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], data_s};
            if (bit_cnt == 4'd14) begin
              bit_cnt <= '0;
              state   <= COMMIT;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              state   <= SHIFT_HI;
            end
          end
        end
        COMMIT:  state <= enable ? LOAD : IDLE;
        IDLE:    if (enable) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  joy_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .commit    (state == COMMIT),
    .word      (shift_reg),
    .joystick1 (joystick1),
    .joystick2 (joystick2)
  );

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl: two instances (CLK_DIV=4/DEBOUNCE=2 and
// CLK_DIV=7/DEBOUNCE=1), each driven by a behavioural 74x165 shifter.
module tb_joy_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b1;
  logic        enable     [2];
  logic [15:0] model_word [2];
  logic [7:0]  js1 [2];
  logic [7:0]  js2 [2];
  logic        fdone [2];
  logic        jload [2];
  logic        jclk  [2];

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  function automatic int cdOf(input int g);
    return (g == 0) ? 4 : 7;
  endfunction

  function automatic int dbOf(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int CDV = (g == 0) ? 4 : 7;
    localparam int DBV = (g == 0) ? 2 : 1;

    joy_scan_ctrl_if pins ();
    logic [15:0] dev   = 16'hFFFF;
    logic        clk_q = 1'b0;

    assign pins.joy_data = dev[15];
    assign jload[g]      = pins.joy_load;
    assign jclk[g]       = pins.joy_clk;

    // Shifter: transparent parallel load while load is low, MSB-first shift on clock rise.
    always @(posedge clk) begin
      clk_q <= pins.joy_clk;
      if (!pins.joy_load) dev <= model_word[g];
      else if (pins.joy_clk && !clk_q) dev <= {dev[14:0], 1'b1};
    end

    joy_scan_ctrl #(.CLK_DIV(CDV), .DEBOUNCE(DBV)) dut (
      .clk_sys    (clk),
      .reset_n    (reset_n),
      .enable     (enable[g]),
      .pins       (pins.master),
      .joystick1  (js1[g]),
      .joystick2  (js2[g]),
      .frame_done (fdone[g])
    );
  end

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] actual=0x%0h expected=0x%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int g, input logic en, input logic [15:0] word);
    enable[g]     = en;
    model_word[g] = word;
  endtask

  // Reference model: frame = 32*CLK_DIV edges then one commit edge; history of frame words.
  bit          m_run   [2] = '{1'b1, 1'b1};
  int          m_phase [2] = '{0, 0};
  logic [15:0] m_js    [2] = '{16'hFFFF, 16'hFFFF};
  bit          m_fd    [2] = '{1'b0, 1'b0};
  logic [15:0] hist    [2][8];
  int          hlen    [2] = '{1, 1};

  always @(posedge clk or negedge reset_n) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) begin
        m_run[g] = 1'b1; m_phase[g] = 0; m_js[g] = 16'hFFFF; m_fd[g] = 1'b0;
        hist[g][7] = 16'hFFFF; hlen[g] = 1;
      end else begin
        m_fd[g] = 1'b0;
        if (m_run[g]) begin
          m_phase[g]++;
          if (m_phase[g] == 32 * cdOf(g) + 1) begin
            int run;
            for (int i = 0; i < 7; i++) hist[g][i] = hist[g][i+1];
            hist[g][7] = model_word[g];
            hlen[g] = (hlen[g] < 8) ? hlen[g] + 1 : 8;
            run = 0;
            for (int i = 7; i >= 8 - hlen[g]; i--) begin
              if (hist[g][i] != hist[g][7]) break;
              run++;
            end
            if (run >= dbOf(g)) m_js[g] = hist[g][7];
            m_fd[g] = 1'b1;
            if (enable[g]) m_phase[g] = 0;
            else m_run[g] = 1'b0;
          end
        end else if (enable[g]) begin
          m_run[g] = 1'b1; m_phase[g] = 0;
        end
      end
    end
  end

  logic prev_load [2];
  logic prev_clk  [2];
  bit   have_prev = 1'b0;
  int   rises [2] = '{0, 0};

  always @(negedge clk) begin
    if (checking) begin
      for (int g = 0; g < 2; g++) begin
        logic exp_load;
        exp_load = !(m_run[g] && m_phase[g] >= 1 && m_phase[g] <= 2 * cdOf(g));
        checkOutput("joystick1", g, 32'(js1[g]), 32'(m_js[g][15:8]));
        checkOutput("joystick2", g, 32'(js2[g]), 32'(m_js[g][7:0]));
        checkOutput("frame_done", g, 32'(fdone[g]), 32'(m_fd[g]));
        checkOutput("joy_load", g, 32'(jload[g]), 32'(exp_load));
        if (!jload[g] || !m_run[g]) checkOutput("joy_clk_quiet", g, 32'(jclk[g]), 32'd0);
        if (have_prev)
          checkOutput("pins_staggered", g,
                      32'((jload[g] != prev_load[g]) && (jclk[g] != prev_clk[g])), 32'd0);
        if (!reset_n) rises[g] = 0;
        else if (have_prev && jclk[g] && !prev_clk[g]) rises[g]++;
        if (fdone[g]) begin
          checkOutput("clk_rises_per_frame", g, 32'(rises[g]), 32'd15);
          rises[g] = 0;
        end
        prev_load[g] = jload[g];
        prev_clk[g]  = jclk[g];
      end
      have_prev = 1'b1;
    end
  end

  task automatic waitFrame(input int g, output int cycles, output int lows);
    int limit;
    limit  = 32 * cdOf(g) + 60;
    cycles = 0;
    lows   = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!jload[g]) lows++;
    end while (!fdone[g] && cycles < limit);
    if (!fdone[g]) checkOutput("frame_timeout", g, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, lows;
    enable[0] = 1'b0; enable[1] = 1'b0;
    model_word[0] = 16'hFFFF; model_word[1] = 16'hA55A;
    #1 reset_n = 1'b0;
    #1 checking = 1'b1;
    applyStimulus(0, 1'b1, 16'hFFFF);
    applyStimulus(1, 1'b1, 16'hA55A);
    repeat (3) @(negedge clk);
    checkOutput("reset_js1", 0, 32'(js1[0]), 32'hFF);
    checkOutput("reset_js2", 0, 32'(js2[0]), 32'hFF);
    checkOutput("reset_load", 0, 32'(jload[0]), 32'd1);
    checkOutput("reset_clk", 0, 32'(jclk[0]), 32'd0);
    checkOutput("reset_fdone", 0, 32'(fdone[0]), 32'd0);
    #2 reset_n = 1'b1;

    fork
      begin : inst0_seq
        int c0, l0, delay;
        logic [15:0] w;
        waitFrame(0, c0, l0);
        checkOutput("first_frame_cycles", 0, 32'(c0), 32'd129);
        checkOutput("load_low_cycles", 0, 32'(l0), 32'd8);
        waitFrame(0, c0, l0);
        checkOutput("frame_period", 0, 32'(c0), 32'd129);
        checkOutput("idle_js1", 0, 32'(js1[0]), 32'hFF);
        checkOutput("idle_js2", 0, 32'(js2[0]), 32'hFF);
        // random frames with frequent repeats so the debouncer both holds and loads
        w = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 2) == 0) w = 16'($urandom);
          applyStimulus(0, 1'b1, w);
          waitFrame(0, c0, l0);
        end
        applyStimulus(0, 1'b1, 16'hFFFF);
        waitFrame(0, c0, l0);
        waitFrame(0, c0, l0);
        waitFrame(0, c0, l0);
        checkOutput("settled_js1", 0, 32'(js1[0]), 32'hFF);
        for (int i = 0; i < 4; i++) begin
          applyStimulus(0, 1'b1, (i % 2 == 0) ? 16'hEFFF : 16'hFFFF);
          waitFrame(0, c0, l0);
          checkOutput("alt_period", 0, 32'(c0), 32'd129);
          checkOutput("alt_js1", 0, 32'(js1[0]), 32'hFF);
          checkOutput("alt_js2", 0, 32'(js2[0]), 32'hFF);
        end
        applyStimulus(0, 1'b1, 16'h7FFE);
        waitFrame(0, c0, l0);
        checkOutput("deb1_js1", 0, 32'(js1[0]), 32'hFF);
        checkOutput("deb1_js2", 0, 32'(js2[0]), 32'hFF);
        waitFrame(0, c0, l0);
        checkOutput("deb2_js1", 0, 32'(js1[0]), 32'h7F);
        checkOutput("deb2_js2", 0, 32'(js2[0]), 32'hFE);
        delay = $urandom_range(20, 100);
        repeat (delay) @(negedge clk);
        applyStimulus(0, 1'b0, 16'h7FFE);
        waitFrame(0, c0, l0);
        checkOutput("drop_frame_cycles", 0, 32'(c0), 32'(129 - delay));
        repeat (20) @(negedge clk);
        checkOutput("park_load", 0, 32'(jload[0]), 32'd1);
        checkOutput("park_clk", 0, 32'(jclk[0]), 32'd0);
        applyStimulus(0, 1'b1, 16'h7FFE);
        repeat (2) @(negedge clk);
        checkOutput("restart_load", 0, 32'(jload[0]), 32'd0);
        waitFrame(0, c0, l0);
        checkOutput("pre_reset_js1", 0, 32'(js1[0]), 32'h7F);
        checkOutput("pre_reset_js2", 0, 32'(js2[0]), 32'hFE);
      end
      begin : inst1_seq
        int c1, l1;
        waitFrame(1, c1, l1);
        checkOutput("nodeb_first_cycles", 1, 32'(c1), 32'd225);
        checkOutput("nodeb_js1", 1, 32'(js1[1]), 32'hA5);
        checkOutput("nodeb_js2", 1, 32'(js2[1]), 32'h5A);
        waitFrame(1, c1, l1);
        checkOutput("nodeb_period", 1, 32'(c1), 32'd225);
        for (int i = 0; i < 3; i++) begin
          applyStimulus(1, 1'b1, 16'($urandom));
          waitFrame(1, c1, l1);
        end
      end
    join

    // Reset during bit 9 of a frame that would otherwise keep 7F/FE.
    repeat (76) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_js1", 0, 32'(js1[0]), 32'hFF);
    checkOutput("midreset_js2", 0, 32'(js2[0]), 32'hFF);
    checkOutput("midreset_load", 0, 32'(jload[0]), 32'd1);
    checkOutput("midreset_clk", 0, 32'(jclk[0]), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    waitFrame(0, cyc, lows);
    checkOutput("post_reset_cycles", 0, 32'(cyc), 32'd129);
    checkOutput("post_reset_load_low", 0, 32'(lows), 32'd8);
    checkOutput("post_reset_js1", 0, 32'(js1[0]), 32'hFF);
    waitFrame(0, cyc, lows);
    checkOutput("post_reset_js1_b", 0, 32'(js1[0]), 32'h7F);
    checkOutput("post_reset_js2_b", 0, 32'(js2[0]), 32'hFE);

    @(negedge clk);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
